// File: rtl/mult_pkg.sv
// Shared types for the shift-add multiplier sequencer.
package mult_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/mult_datapath.sv
// Magnitude capture, shift-add accumulator and final sign fix-up.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             finish,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             mag_b_next_zero,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    prod_q, prod_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] shifted;
    logic [PW-1:0]    sum;

    // Most-negative value negates to itself, read back as unsigned 2^(W-1).
    assign a_neg = is_signed & op_a[WIDTH-1];
    assign b_neg = is_signed & op_b[WIDTH-1];
    assign mag_a = a_neg ? -op_a : op_a;
    assign mag_b = b_neg ? -op_b : op_b;

    assign shifted         = mplier_q >> 1;
    assign sum             = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mag_b_next_zero = (shifted == '0);

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        prod_d   = prod_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, mag_a};
            mplier_d = mag_b;
            acc_d    = '0;
            neg_d    = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        end else if (step) begin
            acc_d    = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = shifted;
            if (finish) begin
                prod_d = neg_q ? -sum : sum;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
        end
    end

    assign product_hi = prod_q[PW-1:WIDTH];
    assign product_lo = prod_q[WIDTH-1:0];

endmodule

// File: rtl/mult_sequencer.sv
// FSM, bit counter and pipeline handshake for the multi-cycle multiplier.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;

    logic load, step, finish;
    logic idle_like, accept, last;
    logic mag_b_next_zero;

    assign idle_like = (state_q == IDLE) | (state_q == DONE);
    assign accept    = idle_like & start & ~flush;
    assign last      = (count_q == CW'(WIDTH - 1))
                     | ((EARLY_EXIT != 0) & mag_b_next_zero);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = RUN;
                    count_d = '0;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    step    = 1'b1;
                    count_d = count_q + CW'(1);
                    if (last) begin
                        finish  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign stall = (start & idle_like) | busy;

    mult_datapath #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk            (clk),
        .reset          (reset),
        .load           (load),
        .step           (step),
        .finish         (finish),
        .is_signed      (is_signed),
        .op_a           (op_a),
        .op_b           (op_b),
        .mag_b_next_zero(mag_b_next_zero),
        .product_hi     (product_hi),
        .product_lo     (product_lo)
    );

endmodule
